// File: rtl/aes_dec_key_sched.sv
// -----------------------------------------------------------------------------
// aes_dec_key_sched
//   Iterative AES-128 key scheduler for the decryption datapath. The cipher
//   key is expanded forward for 10 cycles to reach round key 10. The schedule
//   is then stepped backwards, and round keys 10 down to 0 are delivered one
//   at a time over a valid/ready handshake. A single 128-bit working register
//   takes the place of an 11-entry round-key table.
//
//   Ports
//     clk       in   1    system clock, rising edge
//     rst       in   1    asynchronous active-high reset
//     start     in   1    begin a schedule (sampled only in IDLE)
//     key       in   128  cipher key, word 0 = key[127:96]
//     busy      out  1    high while expanding or emitting
//     rk_valid  out  1    rk / rk_idx hold a valid round key
//     rk_ready  in   1    consumer accepts rk on rk_valid && rk_ready
//     rk        out  128  current round key, same word order as key
//     rk_idx    out  4    round number of rk (10 down to 0)
//     done      out  1    one-cycle pulse after round key 0 is accepted
//
//   Optional build macro: AES_DEC_KEY_CACHE_EN
//     When defined, the last cipher key and its K10 are cached. A repeated
//     start with the same key skips the forward expansion.
//
//   aes_dec_sbox is the combinational AES S-box (GF(2^8) inverse + affine).
// -----------------------------------------------------------------------------

module aes_dec_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            acc = acc ^ aa;
         end else begin
            acc = acc;
         end
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // S-box: x^254 is the multiplicative inverse (and maps 0 to 0), then the affine map
   function automatic logic [7:0] sbox_fn(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Pure combinational lookup
   always_comb begin
      out_o = sbox_fn(in_i);
   end

endmodule

module aes_dec_key_sched #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk,
   output logic [3:0]   rk_idx,
   output logic         done
);

   if (NR != 10) begin : g_nr_check
      $fatal(1, "aes_dec_key_sched: only NR=10 (AES-128) is supported");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_EMIT   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [127:0]   rk_q, rk_d;
   logic [3:0]     idx_q, idx_d;
   logic           valid_q, valid_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;

   logic           handshake_s;
   logic           cache_hit_s;
   logic [127:0]   cache_k10_s;
   logic [31:0]    w0_s, w1_s, w2_s, w3_s;
   logic [31:0]    inv_d_s;
   logic [31:0]    sub_in_s, rot_s, sub_s, t_s;
   logic [3:0]     rcon_idx_s;
   logic [7:0]     rcon_s;
   logic [127:0]   fwd_s, inv_s;

   // Round constants, indexed by the round number of the key being produced/undone
   function automatic logic [7:0] rcon_rom(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   assign handshake_s = valid_q & rk_ready;

   // Shared forward/inverse step datapath
   always_comb begin
      w0_s    = rk_q[127:96];
      w1_s    = rk_q[95:64];
      w2_s    = rk_q[63:32];
      w3_s    = rk_q[31:0];
      inv_d_s = w3_s ^ w2_s;
      // The inverse step needs SubWord of the recovered last word, the forward step of the current one
      if (state_q == ST_EMIT) begin
         sub_in_s   = inv_d_s;
         rcon_idx_s = idx_q;
      end else begin
         sub_in_s   = w3_s;
         rcon_idx_s = idx_q + 4'd1;
      end
      rot_s  = {sub_in_s[23:0], sub_in_s[31:24]};
      rcon_s = rcon_rom(rcon_idx_s);
      t_s    = sub_s ^ {rcon_s, 24'h000000};
      fwd_s[127:96] = w0_s ^ t_s;
      fwd_s[95:64]  = w1_s ^ fwd_s[127:96];
      fwd_s[63:32]  = w2_s ^ fwd_s[95:64];
      fwd_s[31:0]   = w3_s ^ fwd_s[63:32];
      inv_s = {w0_s ^ t_s, w1_s ^ w0_s, w2_s ^ w1_s, inv_d_s};
   end

   aes_dec_sbox u_sbox3 (.in_i(rot_s[31:24]), .out_o(sub_s[31:24]));
   aes_dec_sbox u_sbox2 (.in_i(rot_s[23:16]), .out_o(sub_s[23:16]));
   aes_dec_sbox u_sbox1 (.in_i(rot_s[15:8]),  .out_o(sub_s[15:8]));
   aes_dec_sbox u_sbox0 (.in_i(rot_s[7:0]),   .out_o(sub_s[7:0]));

`ifdef AES_DEC_KEY_CACHE_EN
   logic [127:0] cached_key_q, cached_key_d;
   logic [127:0] cached_k10_q, cached_k10_d;
   logic         cache_valid_q, cache_valid_d;

   assign cache_hit_s = cache_valid_q & (key == cached_key_q);
   assign cache_k10_s = cached_k10_q;

   // Cache update: key captured on a missing start, K10 and valid set on entry to EMIT
   always_comb begin
      cached_key_d  = cached_key_q;
      cached_k10_d  = cached_k10_q;
      cache_valid_d = cache_valid_q;
      if (state_q == ST_IDLE && start && !cache_hit_s) begin
         cached_key_d  = key;
         cache_valid_d = 1'b0;
      end else if (state_q == ST_EXPAND && idx_q == 4'd9) begin
         cached_k10_d  = fwd_s;
         cache_valid_d = 1'b1;
      end else begin
         cache_valid_d = cache_valid_q;
      end
   end

   // Cache registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cached_key_q  <= 128'h0;
         cached_k10_q  <= 128'h0;
         cache_valid_q <= 1'b0;
      end else begin
         cached_key_q  <= cached_key_d;
         cached_k10_q  <= cached_k10_d;
         cache_valid_q <= cache_valid_d;
      end
   end
`else
   assign cache_hit_s = 1'b0;
   assign cache_k10_s = 128'h0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = cache_hit_s ? ST_EMIT : ST_EXPAND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXPAND: begin
            if (idx_q == 4'd9) begin
               state_d = ST_EMIT;
            end else begin
               state_d = ST_EXPAND;
            end
         end
         ST_EMIT: begin
            if (handshake_s && idx_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_EMIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and working-register next values
   always_comb begin
      rk_d    = rk_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (start && cache_hit_s) begin
               rk_d    = cache_k10_s;
               idx_d   = 4'd10;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end else if (start) begin
               rk_d    = key;
               idx_d   = 4'd0;
               valid_d = 1'b0;
               busy_d  = 1'b1;
            end else begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         end
         ST_EXPAND: begin
            rk_d    = fwd_s;
            idx_d   = idx_q + 4'd1;
            valid_d = (idx_q == 4'd9);
         end
         ST_EMIT: begin
            // Accepting K0 ends the schedule; rk keeps K0 while idle
            if (handshake_s && idx_q == 4'd0) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (handshake_s) begin
               rk_d  = inv_s;
               idx_d = idx_q - 4'd1;
            end else begin
               rk_d = rk_q;
            end
         end
         default: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Working and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rk_q    <= 128'h0;
         idx_q   <= 4'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         rk_q    <= rk_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign rk       = rk_q;
   assign rk_idx   = idx_q;
   assign rk_valid = valid_q;
   assign done     = done_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_dec_key_sched
//   Self-checking bench for aes_dec_key_sched. A reference model builds the
//   full FIPS-197 word expansion (w[0..43]) with its own S-box table and
//   computes the expected round keys. Inputs are driven and outputs sampled
//   on the falling clock edge.
//   Expected first-valid latency depends on AES_DEC_KEY_CACHE_EN.
// -----------------------------------------------------------------------------
module tb_aes_dec_key_sched;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam int MISS_LAT = 11;   // start cycle -> first cycle with rk_valid
`ifdef AES_DEC_KEY_CACHE_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = 11;
`endif

   logic         clk = 1'b0;
   logic         rst, start, rk_ready;
   logic [127:0] key;
   logic         busy, rk_valid, done;
   logic [127:0] rk;
   logic [3:0]   rk_idx;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]   sbox_tbl [0:255];
   logic [127:0] exp_rk   [0:10];

   always #5 clk = ~clk;

   aes_dec_key_sched dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key      (key),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk       (rk),
      .rk_idx   (rk_idx),
      .done     (done)
   );

   task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
      return (v << s) | (v >> (8 - s));
   endfunction

   // S-box table from the generator-3 / inverse-generator walk
   task automatic build_sbox();
      logic [7:0] p, q;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         sbox_tbl[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      end while (p != 8'h01);
      sbox_tbl[0] = 8'h63;
   endtask

   // Standard AES-128 key expansion into exp_rk[0..10]
   task automatic fill_model(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // One full schedule: start, wait for K10, drain 11 keys, check done
   task automatic run_sched(input logic [127:0] k, input bit rnd_ready, input int exp_lat, input bit poke);
      int n;
      int exp_idx;
      bit stalled, rdy, finished;
      logic [127:0] prev_rk;
      logic [3:0]   prev_idx;
      fill_model(k);
      @(negedge clk);
      key = k; start = 1'b1; rk_ready = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         key = {$urandom, $urandom, $urandom, $urandom};
         rk_ready = ($urandom_range(0, 1) == 1);
         n++;
         check_value("busy_run", busy, 1);
         if (poke && n == 4) begin
            start = 1'b1;
            key = 128'h0;
         end
      end while (!rk_valid && n < 40);
      check_value("latency", n, exp_lat);

      exp_idx = 10; stalled = 0; finished = 0; prev_rk = '0; prev_idx = '0;
      for (int c = 0; c < 200 && !finished; c++) begin
         if (stalled) begin
            check_value("hold_rk", rk, prev_rk);
            check_value("hold_idx", rk_idx, prev_idx);
         end
         check_value("valid", rk_valid, 1);
         rdy = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
         rk_ready = rdy;
         if (poke && c == 3) begin
            start = 1'b1;
            key = 128'h0;
         end else begin
            start = 1'b0;
         end
         if (rdy) begin
            check_value("rk_idx", rk_idx, exp_idx);
            check_value("rk", rk, exp_rk[exp_idx]);
            if (k == FIPS_KEY && exp_idx == 10) check_value("fips_k10", rk, FIPS_K10);
            if (k == FIPS_KEY && exp_idx == 1)  check_value("fips_k1", rk, FIPS_K1);
            if (k == 128'h0 && exp_idx == 10)   check_value("zero_k10", rk, ZERO_K10);
            if (exp_idx == 0) begin
               check_value("k0_is_key", rk, k);
               finished = 1;
            end else begin
               exp_idx--;
            end
         end
         stalled = !rdy;
         prev_rk = rk;
         prev_idx = rk_idx;
         @(negedge clk);
      end
      start = 1'b0;
      check_value("emit_finished", finished, 1);
      check_value("done_pulse", done, 1);
      check_value("valid_after", rk_valid, 0);
      check_value("busy_after", busy, 0);
      check_value("rk_idle", rk, k);
      check_value("idx_idle", rk_idx, 0);
      rk_ready = 1'b0;
      @(negedge clk);
      check_value("done_single", done, 0);
      check_value("rk_still_k0", rk, k);
   endtask

   initial begin
      int n;
      build_sbox();
      rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key = 128'h0;
      #12;
      check_value("rst_busy", busy, 0);
      check_value("rst_valid", rk_valid, 0);
      check_value("rst_done", done, 0);
      check_value("rst_rk", rk, 0);
      check_value("rst_idx", rk_idx, 0);
      @(negedge clk);
      rst = 1'b0;

      // FIPS-197 key, consumer always ready
      run_sched(FIPS_KEY, 1'b0, MISS_LAT, 1'b0);
      // Same key under backpressure (cache hit when the cache is built in)
      run_sched(FIPS_KEY, 1'b1, HIT_LAT, 1'b0);
      // Random keys under backpressure
      for (int i = 0; i < 3; i++)
         run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b1, MISS_LAT, 1'b0);
      // Start pulses while busy must not disturb the sequence
      run_sched(FIPS_KEY, 1'b0, MISS_LAT, 1'b1);

      // Reset in EMIT at rk_idx 6
      @(negedge clk);
      start = 1'b1; key = FIPS_KEY; rk_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         n++;
      end while (!(rk_valid && rk_idx == 4'd6) && n < 60);
      check_value("reach_idx6", rk_idx, 6);
      rk_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_value("mid_rst_valid", rk_valid, 0);
      check_value("mid_rst_busy", busy, 0);
      check_value("mid_rst_rk", rk, 0);
      check_value("mid_rst_idx", rk_idx, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_value("post_rst_valid", rk_valid, 0);
      check_value("post_rst_rk", rk, 0);

      // All-zero key after reset, then repeated, then a different key
      run_sched(128'h0, 1'b0, MISS_LAT, 1'b0);
      run_sched(128'h0, 1'b1, HIT_LAT, 1'b0);
      run_sched(FIPS_KEY, 1'b0, MISS_LAT, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
